// File: rtl/press_count_ctrl.sv
// press_count_ctrl: turns a single push-button level into RUN/HOLD toggles and
// long-press clears, and sequences a wrapping count register.
// Optional input filter: define PRESS_DEBOUNCE_EN to debounce press over
// DEB_CYCLES edges before it reaches the edge and long-press logic.
module press_count_ctrl #(
  parameter int WIDTH       = 4,
  parameter int MAX_COUNT   = 15,
  parameter int LONG_CYCLES = 8,
  parameter int DEB_CYCLES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             holding,
  output logic             wrap
);

  // Elaboration-time parameter legality checks.
  if (MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max_count
    $error("press_count_ctrl: MAX_COUNT does not fit in WIDTH bits");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long_cycles
    $error("press_count_ctrl: LONG_CYCLES must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("press_count_ctrl: DEB_CYCLES must be at least 1");
  end

  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0]    LONG_SAT  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0]    LONG_CLR  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]    LONG_ONE  = LW'(1);
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic p_s;
  logic rise_s;
  logic clear_s;

  logic             press_q,   press_d;
  logic [LW-1:0]    long_q,    long_d;
  state_t           state_q,   state_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic             wrap_q,    wrap_d;
  logic             running_q, running_d;
  logic             holding_q, holding_d;

`ifdef PRESS_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic          filt_q, filt_d;
  logic [DW-1:0] deb_q,  deb_d;

  // Debounce: adopt press only after it has disagreed with p for DEB_CYCLES edges.
  always_comb begin
    filt_d = filt_q;
    deb_d  = {DW{1'b0}};
    if (press != filt_q) begin
      if (deb_q == DEB_LAST) begin
        filt_d = press;
        deb_d  = {DW{1'b0}};
      end else begin
        filt_d = filt_q;
        deb_d  = deb_q + DEB_ONE;
      end
    end else begin
      filt_d = filt_q;
      deb_d  = {DW{1'b0}};
    end
  end

  // Debounce filter state; idles high so a held button is not seen as a new press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_q <= 1'b1;
      deb_q  <= {DW{1'b0}};
    end else begin
      filt_q <= filt_d;
      deb_q  <= deb_d;
    end
  end

  assign p_s = filt_q;
`else
  assign p_s = press;
`endif

  assign rise_s  = p_s & ~press_q;
  assign clear_s = p_s & (long_q == LONG_CLR);

  // Next-state: clear beats toggle, toggle beats counting; outputs follow next state.
  always_comb begin
    press_d = p_s;
    long_d  = long_q;
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;

    if (p_s) begin
      if (long_q == LONG_SAT) begin
        long_d = long_q;
      end else begin
        long_d = long_q + LONG_ONE;
      end
    end else begin
      long_d = {LW{1'b0}};
    end

    if (clear_s) begin
      state_d = ST_IDLE;
      count_d = {WIDTH{1'b0}};
    end else if (rise_s) begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  state_d = ST_HOLD;
        ST_HOLD: state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_RUN) begin
      if (count_q == COUNT_MAX) begin
        count_d = {WIDTH{1'b0}};
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
    end else begin
      count_d = count_q;
    end

    running_d = (state_d == ST_RUN);
    holding_d = (state_d == ST_HOLD);
  end

  // State, count and registered status outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      press_q   <= 1'b1;
      long_q    <= {LW{1'b0}};
      state_q   <= ST_IDLE;
      count_q   <= {WIDTH{1'b0}};
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      long_q    <= long_d;
      state_q   <= state_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
      holding_q <= holding_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign holding = holding_q;
  assign wrap    = wrap_q;

endmodule
